// File: rtl/sub_pkg.sv
`default_nettype none
//============================================================================
// Module      : sub_pkg
// Description : Shared constants and FSM state encoding for the bit-serial
//               subtractor.
// Revision    : 1.0 - initial release
//============================================================================
package sub_pkg;

    // Default operand/result width of the serial subtractor.
    localparam int c_width_default = 10;

    // Control FSM states: waiting for operands, shifting bits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
//============================================================================
// Module      : full_subtractor
// Description : One-bit combinational full subtractor (a - b - bin).
// Revision    : 1.0 - initial release
//============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_sub10.sv
`default_nettype none
//============================================================================
// Module      : serial_sub10
// Description : Bit-serial unsigned subtractor, LSB first, one bit per clock,
//               with valid/ready handshakes on operands and result.
// Revision    : 1.0 - initial release
//============================================================================
module serial_sub10
    import sub_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy
);

    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_bout;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_bit_diff;
    logic               w_bit_bout;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == c_cnt_last);

    // Operand registers shift right, so the bit being processed is always bit 0.
    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .diff (w_bit_diff),
        .bout (w_bit_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/status outputs decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE here means the earliest re-accept is the next cycle.
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, then shift one difference bit in per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_borrow <= Bin;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_borrow <= w_bit_bout;
                    // After WIDTH shifts the LSB-first bits have landed in order.
                    r_diff   <= {w_bit_diff, r_diff[WIDTH-1:1]};
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_bout <= w_bit_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;

endmodule : serial_sub10
`default_nettype wire

// File: tb/tb_serial_sub10.sv
`default_nettype none
//============================================================================
// Module      : tb_serial_sub10
// Description : Self-checking bench for serial_sub10 with a scoreboard and
//               an arithmetic reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_serial_sub10;

    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         busy;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests;
    int   n_fail;
    int   cyc;
    int   last_acc;
    bit   rand_ready;

    serial_sub10 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Reference: unsigned A - B - Bin modulo 2^W, borrow when A < B + Bin.
    function automatic exp_t model(input int a, input int b, input int bi, input int acc);
        exp_t e;
        int   d;
        d = a - b - bi;
        if (d < 0) d = d + (1 << W);
        e.diff = W'(d);
        e.bout = (a < (b + bi));
        e.acc  = acc;
        return e;
    endfunction

    // Input-side monitor: an accept happens on the coming edge when valid and ready.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && in_valid && in_ready) begin
                e = cyc + 1;
                if (last_acc >= 0) chk("accept_spacing", 32'(e - last_acc >= W + 2), 1);
                last_acc = e;
                sb.push_back(model(int'(A), int'(B), int'(Bin), e));
            end
        end
    end

    // Output-side monitor: latency, hold-while-stalled and result checks.
    initial begin
        bit           prev_ov;
        bit           held;
        logic [W-1:0] hd;
        logic         hb;
        exp_t         e;
        prev_ov = 1'b0;
        held    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
                held    = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!prev_ov) begin
                    if (sb.size() == 0) note_fail("unexpected_result");
                    else chk("latency", 32'(cyc - sb[0].acc), W);
                end
                chk("done_in_ready", in_ready, 0);
                chk("done_busy", busy, 0);
                if (held) begin
                    chk("hold_diff", Diff, hd);
                    chk("hold_bout", Bout, hb);
                end
                held = 1'b1;
                hd   = Diff;
                hb   = Bout;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        note_fail("result_without_op");
                    end else begin
                        e = sb.pop_front();
                        chk("diff", Diff, e.diff);
                        chk("bout", Bout, e.bout);
                    end
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
            prev_ov = out_valid;
        end
    end

    // Optional random consumer backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one operand set for a single accepted cycle, then scramble the inputs.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) note_fail("in_ready_timeout");
        A        = a;
        B        = b;
        Bin      = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("accept_busy", busy, 1);
        A   = W'($urandom);
        B   = W'($urandom);
        Bin = 1'($urandom);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) note_fail("drain_timeout");
    endtask

    initial begin
        int t;
        n_tests    = 0;
        n_fail     = 0;
        last_acc   = -1000;
        rand_ready = 1'b0;
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        Bin        = 1'b0;
        out_ready  = 1'b1;

        // Reset values.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors; the first is accepted on the first edge after reset release.
        send(10'd700, 10'd300, 1'b0);
        wait_done();
        send(10'd0, 10'd1, 1'b0);
        wait_done();
        send(10'd5, 10'd5, 1'b1);
        wait_done();
        send(10'd1023, 10'd0, 1'b1);
        wait_done();

        // Backpressure in DONE, then release; result must persist in IDLE.
        out_ready = 1'b0;
        send(10'd700, 10'd300, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) note_fail("out_valid_timeout");
        repeat (5) @(posedge clk);
        #1;
        chk("bp_diff", Diff, 400);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);
        chk("idle_keeps_diff", Diff, 400);
        chk("idle_keeps_bout", Bout, 0);
        wait_done();

        // Reset four cycles into RUN aborts the operation.
        send(10'd123, 10'd456, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_diff", Diff, 0);
        chk("abort_bout", Bout, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        sb.delete();
        last_acc = -1000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(10'd9, 10'd3, 1'b0);
        wait_done();

        // Random operands (including extremes) with random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0:       send(10'd0, W'($urandom), 1'($urandom));
                1:       send(10'd1023, W'($urandom), 1'($urandom));
                default: send(W'($urandom), W'($urandom), 1'($urandom));
            endcase
        end
        wait_done();

        // in_valid held high with operands changing every cycle.
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            A   = W'($urandom);
            B   = W'($urandom);
            Bin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done();

        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        wait_done();
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_sub10
`default_nettype wire
